// File: rtl/params_mem_arb.sv
// Arbiter for the parameter memory. Several round-robin readers and one writer share a single-port memory.
// Writes normally win; reads are forced through after STARVE_MAX write grants in a row.
module params_mem_arb #(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 22,
  parameter int unsigned FMT_W      = 2,
  parameter int unsigned DEPTH      = 31744,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          rd_req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   rd_req_addr,
  input  logic [N_REQ*FMT_W-1:0]    rd_req_format,
  output logic [N_REQ-1:0]          rd_req_ready,
  output logic [N_REQ-1:0]          rd_rsp_valid,
  output logic [DATA_W-1:0]         rd_rsp_data,
  output logic                      rd_rsp_err,
  input  logic                      wr_req_valid,
  input  logic [ADDR_W-1:0]         wr_req_addr,
  input  logic [DATA_W-1:0]         wr_req_data,
  input  logic [FMT_W-1:0]          wr_req_format,
  output logic                      wr_req_ready,
  output logic                      wr_err,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  output logic [FMT_W-1:0]          mem_rd_format,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic                      mem_wr_en,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  output logic [FMT_W-1:0]          mem_wr_format,
  output logic                      mem_chip_en
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  logic              rsp_valid;
  logic [IDX_W-1:0]  rsp_idx;
  logic              rsp_err;
  logic              wr_err_q;

  logic              any_rd;
  logic              rd_found;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              rd_in_range;
  logic              wr_in_range;

  logic [ADDR_W-1:0] req_addr [N_REQ];
  logic [FMT_W-1:0]  req_fmt  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_addr[gi] = rd_req_addr[gi*ADDR_W +: ADDR_W];
    assign req_fmt[gi]  = rd_req_format[gi*FMT_W +: FMT_W];
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    rd_found = 1'b0;
    rd_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!rd_found && rd_req_valid[IDX_W'((32'(rr_ptr) + k) % N_REQ)]) begin
        rd_found = 1'b1;
        rd_idx   = IDX_W'((32'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign any_rd      = |rd_req_valid;
  assign rd_gnt      = rst_n && rd_found && (!wr_req_valid || (starve_cnt == STARVE_TOP));
  assign wr_gnt      = rst_n && wr_req_valid && !rd_gnt;
  assign rd_in_range = 32'(req_addr[rd_idx]) < DEPTH;
  assign wr_in_range = 32'(wr_req_addr) < DEPTH;

  // Grants and memory port; everything idles at zero when nothing is granted.
  always_comb begin
    rd_req_ready  = '0;
    wr_req_ready  = wr_gnt;
    mem_rd_en     = 1'b0;
    mem_rd_addr   = '0;
    mem_rd_format = '0;
    mem_wr_en     = 1'b0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;
    mem_wr_format = '0;
    rd_rsp_valid  = '0;
    if (rd_gnt) begin
      rd_req_ready[rd_idx] = 1'b1;
    end
    if (rd_gnt && rd_in_range) begin
      mem_rd_en     = 1'b1;
      mem_rd_addr   = req_addr[rd_idx];
      mem_rd_format = req_fmt[rd_idx];
    end
    if (wr_gnt && wr_in_range) begin
      mem_wr_en     = 1'b1;
      mem_wr_addr   = wr_req_addr;
      mem_wr_data   = wr_req_data;
      mem_wr_format = wr_req_format;
    end
    if (rsp_valid) begin
      rd_rsp_valid[rsp_idx] = 1'b1;
    end
  end

  assign rd_rsp_data = (rsp_valid && !rsp_err) ? mem_rd_data : '0;
  assign rd_rsp_err  = rsp_valid && rsp_err;
  assign wr_err      = wr_err_q;
  assign mem_chip_en = rst_n;

  // Round-robin pointer, starvation counter and the one-deep response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_idx    <= '0;
      rsp_err    <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rsp_valid <= rd_gnt;
      rsp_idx   <= rd_idx;
      rsp_err   <= rd_gnt && !rd_in_range;
      wr_err_q  <= wr_gnt && !wr_in_range;
      if (rd_gnt) begin
        rr_ptr <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
      if (!any_rd || rd_gnt) begin
        starve_cnt <= '0;
      end else if (wr_gnt && (starve_cnt != STARVE_TOP)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`ifdef ENABLE_ASSERTIONS
  a_mem_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_rd_en && mem_wr_en));
  a_rdy_oh:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rd_req_ready));
  a_rsp_oh:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rd_rsp_valid));
`endif

endmodule

// File: tb/tb_params_mem_arb.sv
// Bench for params_mem_arb: directed scenarios plus a randomized run against a cycle-level arbitration model.
module tb_params_mem_arb;

  // 16 address bits so that 40000 is a representable out-of-range write address.
  localparam int N = 3, AW = 16, DW = 22, FW = 2, DEPTH = 31744, SMAX = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    rd_req_valid;
  logic [N*AW-1:0] rd_req_addr;
  logic [N*FW-1:0] rd_req_format;
  logic [N-1:0]    rd_req_ready, rd_rsp_valid;
  logic [DW-1:0]   rd_rsp_data;
  logic            rd_rsp_err;
  logic            wr_req_valid;
  logic [AW-1:0]   wr_req_addr;
  logic [DW-1:0]   wr_req_data;
  logic [FW-1:0]   wr_req_format;
  logic            wr_req_ready, wr_err;
  logic            mem_rd_en, mem_wr_en, mem_chip_en;
  logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
  logic [FW-1:0]   mem_rd_format, mem_wr_format;
  logic [DW-1:0]   mem_rd_data = '0;
  logic [DW-1:0]   mem_wr_data;

  params_mem_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FMT_W(FW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_format(rd_req_format),
    .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_err(rd_rsp_err), .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_format(wr_req_format), .wr_req_ready(wr_req_ready),
    .wr_err(wr_err), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_format(mem_rd_format),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_format(mem_wr_format), .mem_chip_en(mem_chip_en)
  );

  always #5 clk = ~clk;

  // Memory: unwritten words read back as addr+1, one cycle after the read enable.
  logic [DW-1:0] bmem [int];
  always @(posedge clk) begin
    if (mem_wr_en) bmem[int'(mem_wr_addr)] = mem_wr_data;
    if (mem_rd_en) mem_rd_data <= bmem.exists(int'(mem_rd_addr)) ? bmem[int'(mem_rd_addr)]
                                                                  : DW'(int'(mem_rd_addr) + 1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int checks = 0, errors = 0;

  // Reference model state
  int            m_rr, m_starve, m_rsp_idx;
  bit            m_rsp_v, m_rsp_err, m_wr_err;
  logic [DW-1:0] m_rsp_data;
  logic [DW-1:0] ref_mem [int];
  int            p_g;
  bit            p_rd, p_wr;

  logic [N-1:0]  e_rd_ready, e_rsp_valid;
  logic          e_wr_ready, e_mem_rd_en, e_mem_wr_en, e_rsp_err, e_wr_err;
  logic [AW-1:0] e_mem_rd_addr, e_mem_wr_addr;
  logic [FW-1:0] e_mem_rd_fmt, e_mem_wr_fmt;
  logic [DW-1:0] e_mem_wr_data, e_rsp_data;

  function automatic int rd_addr_of(int i);
    return int'(rd_req_addr[i*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] ref_read(int a);
    return ref_mem.exists(a) ? ref_mem[a] : DW'(a + 1);
  endfunction

  task automatic set_rd(int i, int a, int f);
    rd_req_addr[i*AW +: AW]   = AW'(a);
    rd_req_format[i*FW +: FW] = FW'(f);
  endtask

  task automatic model_reset();
    m_rr = 0; m_starve = 0; m_rsp_v = 0; m_rsp_idx = 0; m_rsp_err = 0; m_rsp_data = '0; m_wr_err = 0;
  endtask

  // Expected outputs for the current cycle from model state and driven inputs.
  task automatic predict();
    bit any_rd;
    int a;
    any_rd = (rd_req_valid != '0);
    p_g = -1;
    for (int k = 0; k < N; k++)
      if (p_g < 0 && rd_req_valid[(m_rr + k) % N]) p_g = (m_rr + k) % N;
    p_rd = any_rd && (!wr_req_valid || m_starve == SMAX);
    p_wr = wr_req_valid && !p_rd;
    e_rd_ready = '0;
    if (p_rd) e_rd_ready[p_g] = 1'b1;
    e_wr_ready = p_wr;
    e_mem_rd_en = 0; e_mem_rd_addr = '0; e_mem_rd_fmt = '0;
    e_mem_wr_en = 0; e_mem_wr_addr = '0; e_mem_wr_fmt = '0; e_mem_wr_data = '0;
    if (p_wr && int'(wr_req_addr) < DEPTH) begin
      e_mem_wr_en = 1; e_mem_wr_addr = wr_req_addr; e_mem_wr_data = wr_req_data; e_mem_wr_fmt = wr_req_format;
    end
    if (p_rd) begin
      a = rd_addr_of(p_g);
      if (a < DEPTH) begin
        e_mem_rd_en = 1; e_mem_rd_addr = AW'(a); e_mem_rd_fmt = rd_req_format[p_g*FW +: FW];
      end
    end
    e_rsp_valid = '0;
    if (m_rsp_v) e_rsp_valid[m_rsp_idx] = 1'b1;
    e_rsp_data = m_rsp_data;
    e_rsp_err  = m_rsp_v && m_rsp_err;
    e_wr_err   = m_wr_err;
  endtask

  task automatic advance();
    bit any_rd;
    int a;
    any_rd = (rd_req_valid != '0);
    m_wr_err = 0;
    if (p_rd) begin
      a = rd_addr_of(p_g);
      m_rr = (p_g + 1) % N;
      m_starve = 0;
      m_rsp_v = 1; m_rsp_idx = p_g; m_rsp_err = (a >= DEPTH);
      m_rsp_data = m_rsp_err ? '0 : ref_read(a);
    end else begin
      m_rsp_v = 0;
    end
    if (p_wr) begin
      m_starve = any_rd ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      if (int'(wr_req_addr) >= DEPTH) m_wr_err = 1;
      else ref_mem[int'(wr_req_addr)] = wr_req_data;
    end
    if (!any_rd) m_starve = 0;
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic clear_inputs();
    rd_req_valid = '0; rd_req_addr = '0; rd_req_format = '0;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0; wr_req_format = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    rd_req_valid = '1; wr_req_valid = 1; wr_req_addr = AW'(5);
    @(negedge clk);
    checks++; if (rd_req_ready !== '0 || wr_req_ready !== 0) begin errors++;
      $display("FAIL reset_grant rd=%b wr=%b exp 0", rd_req_ready, wr_req_ready); end
    checks++; if (mem_chip_en !== 0 || mem_rd_en !== 0 || mem_wr_en !== 0) begin errors++;
      $display("FAIL reset_mem ce=%b re=%b we=%b exp 0", mem_chip_en, mem_rd_en, mem_wr_en); end
    checks++; if (rd_rsp_valid !== '0 || wr_err !== 0 || int'(dut.starve_cnt) !== 0) begin errors++;
      $display("FAIL reset_state rsp=%b werr=%b starve=%0d exp 0", rd_rsp_valid, wr_err, dut.starve_cnt); end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1;
    model_reset();
    predict();
    @(negedge clk);
    checks++; if (mem_chip_en !== 1) begin errors++; $display("FAIL chip_en got=%b exp 1", mem_chip_en); end
    checks++; if ({mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_format, mem_wr_format} !== '0)
      begin errors++; $display("FAIL idle_mem outputs not all zero"); end
    step();
  endtask

  task automatic test_round_robin();
    rd_req_valid = 3'b111;
    set_rd(0, 10, 1); set_rd(1, 20, 2); set_rd(2, 30, 3);
    for (int c = 0; c < 8; c++) begin
      if (c == 7) rd_req_valid = '0;
      predict();
      @(negedge clk);
      if (c < 7) begin
        checks++; if (rd_req_ready !== e_rd_ready || rd_req_ready !== 3'(1 << (c % 3))) begin errors++;
          $display("FAIL rr_grant c=%0d got=%b exp=%b", c, rd_req_ready, 3'(1 << (c % 3))); end
        checks++; if (mem_rd_en !== 1 || mem_rd_addr !== e_mem_rd_addr || mem_rd_format !== e_mem_rd_fmt) begin
          errors++; $display("FAIL rr_mem c=%0d en=%b addr=%0d fmt=%0d exp addr=%0d fmt=%0d",
                             c, mem_rd_en, mem_rd_addr, mem_rd_format, e_mem_rd_addr, e_mem_rd_fmt); end
      end
      checks++; if (rd_rsp_valid !== e_rsp_valid) begin errors++;
        $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rd_rsp_valid, e_rsp_valid); end
      if (c > 0) begin
        checks++; if (rd_rsp_data !== DW'(10 * ((c - 1) % 3 + 1) + 1) || rd_rsp_err !== 0) begin errors++;
          $display("FAIL rr_rsp_data c=%0d got=%0d exp=%0d", c, rd_rsp_data, 10 * ((c - 1) % 3 + 1) + 1); end
      end
      step();
    end
  endtask

  task automatic test_starvation();
    rd_req_valid = 3'b010; set_rd(1, 100, 1);
    wr_req_valid = 1; wr_req_addr = AW'(50); wr_req_data = DW'($urandom); wr_req_format = 2'd1;
    for (int c = 0; c < 12; c++) begin
      predict();
      @(negedge clk);
      checks++; if (wr_req_ready !== e_wr_ready || rd_req_ready !== e_rd_ready) begin errors++;
        $display("FAIL starve_grant c=%0d wr=%b rd=%b exp wr=%b rd=%b", c, wr_req_ready, rd_req_ready, e_wr_ready, e_rd_ready); end
      checks++; if (int'(dut.starve_cnt) !== m_starve) begin errors++;
        $display("FAIL starve_cnt c=%0d got=%0d exp=%0d", c, dut.starve_cnt, m_starve); end
      checks++; if (mem_wr_en !== e_mem_wr_en || mem_rd_en !== e_mem_rd_en) begin errors++;
        $display("FAIL starve_mem c=%0d we=%b re=%b exp we=%b re=%b", c, mem_wr_en, mem_rd_en, e_mem_wr_en, e_mem_rd_en); end
      if (c == 4) begin
        checks++; if (rd_req_ready !== 3'b010) begin errors++;
          $display("FAIL starve_fifth c=%0d got=%b exp=010", c, rd_req_ready); end
      end
      step();
    end
    clear_inputs();
    predict(); step();
  endtask

  task automatic test_oob_read();
    rd_req_valid = 3'b100; set_rd(2, DEPTH, 1);
    predict();
    @(negedge clk);
    checks++; if (rd_req_ready !== 3'b100 || mem_rd_en !== 0) begin errors++;
      $display("FAIL oob_rd_grant rdy=%b re=%b exp 100/0", rd_req_ready, mem_rd_en); end
    step();
    rd_req_valid = '0;
    predict();
    @(negedge clk);
    checks++; if (rd_rsp_valid !== 3'b100 || rd_rsp_data !== '0 || rd_rsp_err !== 1) begin errors++;
      $display("FAIL oob_rd_rsp v=%b d=%0d e=%b exp 100/0/1", rd_rsp_valid, rd_rsp_data, rd_rsp_err); end
    step();
  endtask

  task automatic test_oob_write();
    wr_req_valid = 1; wr_req_addr = AW'(40000); wr_req_data = DW'(7);
    predict();
    @(negedge clk);
    checks++; if (wr_req_ready !== 1 || mem_wr_en !== 0) begin errors++;
      $display("FAIL oob_wr_grant rdy=%b we=%b exp 1/0", wr_req_ready, mem_wr_en); end
    step();
    wr_req_valid = 0;
    predict();
    @(negedge clk);
    checks++; if (wr_err !== 1) begin errors++; $display("FAIL oob_wr_err got=%b exp 1", wr_err); end
    step();
    predict();
    @(negedge clk);
    checks++; if (wr_err !== 0) begin errors++; $display("FAIL oob_wr_err_pulse got=%b exp 0", wr_err); end
    step();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = DW'($urandom);
    wr_req_valid = 1; wr_req_addr = AW'(15872); wr_req_data = d; wr_req_format = 2'd2;
    predict();
    @(negedge clk);
    checks++; if (mem_wr_en !== 1 || mem_wr_addr !== AW'(15872) || mem_wr_format !== 2'd2 || mem_wr_data !== d) begin
      errors++; $display("FAIL wr_port en=%b addr=%0d fmt=%0d data=%0h exp 1/15872/2/%0h",
                         mem_wr_en, mem_wr_addr, mem_wr_format, mem_wr_data, d); end
    step();
    wr_req_valid = 0;
    rd_req_valid = 3'b001; set_rd(0, 15872, 2);
    predict();
    @(negedge clk);
    checks++; if (mem_rd_en !== 1 || mem_rd_addr !== AW'(15872) || mem_rd_format !== 2'd2) begin errors++;
      $display("FAIL rd_port en=%b addr=%0d fmt=%0d exp 1/15872/2", mem_rd_en, mem_rd_addr, mem_rd_format); end
    step();
    rd_req_valid = '0;
    predict();
    @(negedge clk);
    checks++; if (rd_rsp_valid !== 3'b001 || rd_rsp_data !== d) begin errors++;
      $display("FAIL wr_rd_rsp v=%b d=%0h exp 001/%0h", rd_rsp_valid, rd_rsp_data, d); end
    step();
  endtask

  task automatic test_reset_mid();
    rd_req_valid = 3'b001; set_rd(0, 3, 0); set_rd(1, 4, 0); set_rd(2, 5, 0);
    predict(); step();
    rd_req_valid = 3'b111;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    checks++; if (rd_rsp_valid !== '0 || rd_req_ready !== '0) begin errors++;
      $display("FAIL mid_reset_out rsp=%b rdy=%b exp 0", rd_rsp_valid, rd_req_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    predict();
    @(negedge clk);
    checks++; if (rd_rsp_valid !== '0 || wr_err !== 0) begin errors++;
      $display("FAIL mid_reset_rsp rsp=%b werr=%b exp 0", rd_rsp_valid, wr_err); end
    checks++; if (rd_req_ready !== 3'b001 || rd_req_ready !== e_rd_ready) begin errors++;
      $display("FAIL mid_reset_rr got=%b exp 001", rd_req_ready); end
    step();
    rd_req_valid = '0;
    predict();
    @(negedge clk);
    checks++; if (rd_rsp_valid !== e_rsp_valid || rd_rsp_data !== e_rsp_data) begin errors++;
      $display("FAIL mid_reset_next v=%b d=%0d exp %b/%0d", rd_rsp_valid, rd_rsp_data, e_rsp_valid, e_rsp_data); end
    step();
  endtask

  function automatic int rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return DEPTH - 1;
    if (r == 1) return DEPTH + $urandom_range(0, 1000);
    if (r < 7)  return $urandom_range(0, 63);
    return $urandom_range(0, DEPTH - 1);
  endfunction

  task automatic test_random();
    clear_inputs();
    for (int c = 0; c < 300; c++) begin
      predict();
      @(negedge clk);
      checks++; if (rd_req_ready !== e_rd_ready || wr_req_ready !== e_wr_ready) begin errors++;
        $display("FAIL rnd_grant c=%0d rd=%b wr=%b exp rd=%b wr=%b", c, rd_req_ready, wr_req_ready, e_rd_ready, e_wr_ready); end
      checks++; if (mem_rd_en !== e_mem_rd_en || mem_rd_addr !== e_mem_rd_addr || mem_rd_format !== e_mem_rd_fmt) begin
        errors++; $display("FAIL rnd_rdport c=%0d en=%b a=%0d f=%0d exp %b/%0d/%0d", c, mem_rd_en, mem_rd_addr,
                           mem_rd_format, e_mem_rd_en, e_mem_rd_addr, e_mem_rd_fmt); end
      checks++; if (mem_wr_en !== e_mem_wr_en || mem_wr_addr !== e_mem_wr_addr || mem_wr_data !== e_mem_wr_data ||
                    mem_wr_format !== e_mem_wr_fmt) begin errors++;
        $display("FAIL rnd_wrport c=%0d en=%b a=%0d exp %b/%0d", c, mem_wr_en, mem_wr_addr, e_mem_wr_en, e_mem_wr_addr); end
      checks++; if (rd_rsp_valid !== e_rsp_valid || rd_rsp_err !== e_rsp_err || wr_err !== e_wr_err) begin errors++;
        $display("FAIL rnd_rsp c=%0d v=%b e=%b we=%b exp %b/%b/%b", c, rd_rsp_valid, rd_rsp_err, wr_err,
                 e_rsp_valid, e_rsp_err, e_wr_err); end
      if (m_rsp_v) begin
        checks++; if (rd_rsp_data !== e_rsp_data) begin errors++;
          $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, rd_rsp_data, e_rsp_data); end
      end
      checks++; if (mem_chip_en !== 1) begin errors++; $display("FAIL rnd_chip_en c=%0d got=%b", c, mem_chip_en); end
      step();
      // Requests stay stable until granted; only idle or just-granted requesters take new values.
      for (int i = 0; i < N; i++) begin
        if (!rd_req_valid[i] || (p_rd && p_g == i)) begin
          rd_req_valid[i] = ($urandom_range(0, 2) != 0);
          set_rd(i, rand_addr(), $urandom_range(0, 3));
        end
      end
      if (!wr_req_valid || p_wr) begin
        wr_req_valid  = ($urandom_range(0, 1) != 0);
        wr_req_addr   = AW'(rand_addr());
        wr_req_data   = DW'($urandom);
        wr_req_format = FW'($urandom_range(0, 3));
      end
    end
    clear_inputs();
    predict(); step();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_starvation();
    test_oob_read();
    test_oob_write();
    test_write_read();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/params_mem_arb.md
PARAMS_MEM_ARB -- requirements
Module: params_mem_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameters SHALL be:
- N_REQ, default 3, number of read requesters.
- ADDR_W, default 15, parameter word address width.
- DATA_W, default 22, CompFx_t width.
- FMT_W, default 2, FxFormatParams_t width.
- DEPTH, default 31744, number of valid words across both banks.
- STARVE_MAX, default 4, maximum consecutive write grants while any read is pending.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- rd_req_valid  in  N_REQ  read request per requester.
- rd_req_addr  in  N_REQ*ADDR_W  read addresses, requester i at slice i.
- rd_req_format  in  N_REQ*FMT_W  cast format per requester.
- rd_req_ready  out  N_REQ  grant, one-hot or zero.
- rd_rsp_valid  out  N_REQ  response strobe, one-hot or zero.
- rd_rsp_data  out  DATA_W  response data, shared by all requesters.
- rd_rsp_err  out  1  response is for an out-of-range address.
- wr_req_valid  in  1  write request.
- wr_req_addr  in  ADDR_W  write address.
- wr_req_data  in  DATA_W  write data.
- wr_req_format  in  FMT_W  write format.
- wr_req_ready  out  1  write grant.
- wr_err  out  1  one-cycle pulse: out-of-range write dropped.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_format  out  FMT_W  memory read format.
- mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  memory write enable.
- mem_wr_addr  out  ADDR_W  memory write address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_wr_format  out  FMT_W  memory write format.
- mem_chip_en  out  1  memory chip enable.

Function
REQ-004 At most one grant SHALL be asserted per cycle across rd_req_ready and wr_req_ready.
REQ-005 Grants SHALL be combinational from the valids and registered state; a transfer occurs on valid&ready at the rising edge of clk.
REQ-006 Requesters SHALL hold valid, address, format and data stable until ready; the block SHALL NOT require ready before valid.
REQ-007 Write priority: wr_req_valid SHALL win over reads unless starve_cnt==STARVE_MAX and any rd_req_valid is set; in that case a read SHALL be granted.
REQ-008 starve_cnt SHALL increment on each write grant made while any read is pending, saturating at STARVE_MAX, and SHALL clear on any read grant or on any cycle with no read pending.
REQ-009 Reads SHALL be arbitrated round-robin: search starts at rr_ptr, ascending modulo N_REQ; after a grant to requester i, rr_ptr <= (i+1) mod N_REQ; rr_ptr SHALL be unchanged when no read is granted.
REQ-010 On an in-range read grant (addr<DEPTH), mem_rd_en=1 and mem_rd_addr/mem_rd_format SHALL equal the granted requester's fields in the same cycle.
REQ-011 For any read grant, one cycle later rd_rsp_valid[i]=1 for exactly that cycle, and rd_rsp_data SHALL equal mem_rd_data.
REQ-012 For an out-of-range read (addr>=DEPTH): grant as normal, mem_rd_en=0, and the response cycle SHALL give rd_rsp_data=0 and rd_rsp_err=1.
REQ-013 Response bookkeeping SHALL be a 1-deep register (valid, requester index, err); back-to-back grants SHALL give back-to-back responses with throughput 1 per cycle.
REQ-014 On an in-range write grant, mem_wr_en=1 and mem_wr_addr/data/format SHALL equal the wr_req fields in the same cycle; mem_rd_en=0 in that cycle.
REQ-015 An out-of-range write SHALL be granted and dropped (mem_wr_en=0), and wr_err SHALL pulse 1 on the following cycle.
REQ-016 mem_chip_en SHALL be 1 whenever out of reset.
REQ-017 When nothing is granted, mem_rd_en=0, mem_wr_en=0, and all mem address/data/format outputs SHALL be 0.
REQ-018 With ENABLE_ASSERTIONS defined, the block SHALL assert: mem_rd_en & mem_wr_en never both set; rd_req_ready one-hot or zero; rd_rsp_valid one-hot or zero.

Reset
REQ-019 While rst_n=0: rr_ptr=0, starve_cnt=0, response register cleared, all outputs 0, including mem_chip_en.
REQ-020 Reset asserted mid-operation SHALL discard any pending response; no rd_rsp_valid or wr_err SHALL occur in the first cycle after deassertion.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- rd_req_valid=3'b111 held, addresses 10/20/30, memory model returns addr+1 -> grants in order 0,1,2,0,...; rd_rsp_valid one cycle later with data 11,21,31.
- wr_req_valid held with rd_req_valid[1] held -> 4 write grants, then 1 read grant to requester 1, then writes resume; starve_cnt pattern 1,2,3,4,0.
- Read of addr 31744 by requester 2 -> mem_rd_en=0; next cycle rd_rsp_valid=3'b100, rd_rsp_data=0, rd_rsp_err=1.
- Write of addr 40000 -> wr_req_ready=1, mem_wr_en=0, wr_err=1 next cycle.
- Write then read of addr 15872, format 2 -> mem_wr_addr=15872, then mem_rd_addr=15872, mem_rd_format=2; response returned one cycle after the read grant.
- rst_n pulsed low the cycle after a read grant -> no rd_rsp_valid; after release rr_ptr=0, so requester 0 wins the next 3'b111 contention.
